prog_ctr_ras: RTL and testbench
===============================

Name: prog_ctr_ras

Overview:
Next-generation program counter for the processor core, generalised from the basic Start/BEQ/JMP counter.
- Parametrised address width and start address.
- Absolute and PC-relative branching.
- Hardware return-address stack (RAS) for call/return.
- Stall input, plus an IDLE/RUN/HALT run-control state machine.
- Feeds the instruction-memory address; the control decoder drives the flags.

Parameters:
A, 10, PC/address width in bits
OW, 6, signed relative-offset width (OW <= A)
DEPTH, 4, RAS entries (power of 2, >= 2)
START_ADDR, 0, PC value loaded on Start

Ports:
clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-low reset (Reset==0 at a rising edge resets)
Start  in  1  start/restart pulse
Halt  in  1  stop fetching (from decoded HALT instruction)
Stall  in  1  hold PC and stack this cycle
beq_flag  in  1  branch taken
rel_flag  in  1  with beq_flag: 1 = relative (PC+Offset), 0 = absolute (Target)
jmp_flag  in  1  unconditional absolute jump to Target
call_flag  in  1  push PC+1, jump to Target
ret_flag  in  1  pop, jump to popped address
Target  in  A  absolute target
Offset  in  OW  signed relative offset
ProgCtr  out  A  current PC
Running  out  1  state==RUN
StackDepth  out  $clog2(DEPTH)+1  valid entries in RAS
StackOvf  out  1  sticky: call attempted with RAS full
StackUnf  out  1  sticky: ret attempted with RAS empty

Behaviour:
- Reset (Reset==0 at edge):
  - state=IDLE, ProgCtr=0, RAS empty (StackDepth=0), StackOvf=StackUnf=0, Running=0.
  - Reset dominates every other input, including mid-run and mid-stall.
- IDLE:
  - PC holds; all flags ignored.
  - Start -> RUN with ProgCtr=START_ADDR next cycle.
- RUN: PC update each cycle unless Stall. Priority ret > call > jmp > beq; lower-priority flags ignored.
  - ret: RAS non-empty -> PC=top, pop. Empty -> PC=PC+1, StackUnf<=1.
  - call: PC=Target. RAS not full -> push PC+1. Full -> see Optional Feature.
  - jmp: PC=Target.
  - beq & rel_flag: PC = PC + sign-extended Offset, mod 2^A.
  - beq & !rel_flag: PC=Target.
  - none: PC=PC+1, mod 2^A (0x3FF -> 0x000 for A=10).
  - Halt: -> HALT; PC, RAS and flags frozen on that edge. Halt has priority over all flags and Stall.
- Stall in RUN: PC, RAS and sticky flags unchanged; flags that cycle are discarded, not queued.
- HALT:
  - PC holds; flags ignored.
  - Start -> RUN, ProgCtr=START_ADDR, RAS cleared, sticky flags cleared.
- Start while already RUN: restart exactly as from HALT (PC=START_ADDR, RAS/sticky cleared); overrides flags and Stall.
- Timing: single-cycle latency; flags sampled at edge N take effect in ProgCtr after edge N. ProgCtr is a registered output.
- Simultaneous push and pop are impossible by priority; ret wins.
- Sticky flags stay set until Reset or Start.

Optional Feature:
RAS_WRAP_EN
- Defined: RAS is circular. Call when full overwrites the oldest entry, StackDepth stays DEPTH, StackOvf still set.
- Undefined: call when full still jumps to Target, but the push is dropped and the RAS is unchanged; StackOvf set.

Decomposition:
- Package prog_ctr_pkg:
  - state enum {IDLE, RUN, HALT};
  - next-PC select enum {SEL_HOLD, SEL_INC, SEL_ABS, SEL_REL, SEL_POP, SEL_START};
  - width helper localparam.
- Sub-module ret_addr_stack (parameters A, DEPTH).
  - Inputs: push, pop, din, clear.
  - Outputs: top, depth, full, empty.
  - Owns wrap/drop logic under RAS_WRAP_EN.
- Top level: FSM plus next-PC mux.

Test Plan:
1. Reset low 1 cycle, Start -> Running=1, ProgCtr 0,1,2,3 on successive edges; Reset low mid-run at PC=5 -> ProgCtr=0, IDLE, StackDepth=0.
2. At PC=0x010:
   - beq, rel=1, Offset=-4 (6'h3C) -> 0x00C.
   - beq, rel=0, Target=0x100 -> 0x100.
   - At PC=0x3FF with no flag -> 0x000.
3. Nested calls from PC=0x020 (Target 0x080), 0x081 (Target 0x0C0) -> StackDepth=2; ret -> 0x082, ret -> 0x021, StackDepth=0; ret again -> PC+1, StackUnf=1.
4. Five calls with DEPTH=4 -> StackOvf=1.
   - Without macro: 4 rets return the first 4 pushed addresses.
   - With RAS_WRAP_EN: 4 rets return calls 5,4,3,2.
5. ret+call+jmp asserted together -> ret honoured. Stall held 3 cycles with jmp -> PC unchanged, jmp discarded.
6. Halt at PC=0x040 -> PC frozen at 0x040, Running=0, flags ignored; Start -> ProgCtr=START_ADDR, RAS and sticky flags cleared.

Source files
------------

// File: rtl/prog_ctr_pkg.sv
// Shared types for the prog_ctr_ras program counter.
// Run-control states, next-PC select codes and the RAS depth-counter width helper.
package prog_ctr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_INC   = 3'd1,
      SEL_ABS   = 3'd2,
      SEL_REL   = 3'd3,
      SEL_POP   = 3'd4,
      SEL_START = 3'd5
   } pc_sel_e;

   // The depth counter needs one bit more than the pointer so it can hold DEPTH itself.
   function automatic int depth_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int RAS_DEPTH_DEFAULT   = 4;
   localparam int RAS_DEPTH_W_DEFAULT = depth_width(RAS_DEPTH_DEFAULT);

endpackage

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack for prog_ctr_ras.
// Circular buffer of DEPTH entries; top is the most recently pushed address.
// Build option RAS_WRAP_EN: a push into a full stack overwrites the oldest entry;
// without it the push is dropped and the stack is left unchanged.
// Pop takes priority over push; clear empties the stack and beats both.
module ret_addr_stack
   import prog_ctr_pkg::*;
#(
   parameter int A     = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [A-1:0]             din,
   output logic [A-1:0]             top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = depth_width(DEPTH);

   logic [A-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_s;
   logic [DW-1:0] depth_r;
   logic          full_s;
   logic          empty_s;
   logic          do_pop_s;
   logic          do_push_s;
   logic          grow_s;

   assign rd_ptr_s = wr_ptr_r - PW'(1'b1);
   assign full_s   = (depth_r == DW'(DEPTH));
   assign empty_s  = (depth_r == {DW{1'b0}});
   assign top      = mem_r[rd_ptr_s];
   assign depth    = depth_r;
   assign full     = full_s;
   assign empty    = empty_s;

   // Decide whether this cycle really pops, pushes, and whether the occupancy grows.
   always_comb begin
      do_pop_s  = pop & ~empty_s;
`ifdef RAS_WRAP_EN
      do_push_s = push & ~pop;
`else
      do_push_s = push & ~pop & ~full_s;
`endif
      grow_s    = do_push_s & ~full_s;
   end

   // Entry storage: a wrapping push lands on the oldest slot, which is where wr_ptr points when full.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr_r <= {PW{1'b0}};
         depth_r  <= {DW{1'b0}};
      end else if (do_pop_s) begin
         wr_ptr_r <= rd_ptr_s;
         depth_r  <= depth_r - DW'(1'b1);
      end else if (do_push_s) begin
         wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         depth_r  <= grow_s ? (depth_r + DW'(1'b1)) : depth_r;
      end else begin
         wr_ptr_r <= wr_ptr_r;
         depth_r  <= depth_r;
      end
   end

endmodule

// File: rtl/prog_ctr_ras.sv
// Program counter with absolute/relative branches, call/return stack and run control.
// IDLE/RUN/HALT state machine plus next-PC mux; all outputs are registered.
// Build option RAS_WRAP_EN selects the overflow behaviour of the return-address stack.
// Start beats Halt when both arrive in RUN: a restart is the stronger request.
module prog_ctr_ras
   import prog_ctr_pkg::*;
#(
   parameter int A          = 10,
   parameter int OW         = 6,
   parameter int DEPTH      = 4,
   parameter int START_ADDR = 0
) (
   input  logic                   clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Halt,
   input  logic                   Stall,
   input  logic                   beq_flag,
   input  logic                   rel_flag,
   input  logic                   jmp_flag,
   input  logic                   call_flag,
   input  logic                   ret_flag,
   input  logic [A-1:0]           Target,
   input  logic [OW-1:0]          Offset,
   output logic [A-1:0]           ProgCtr,
   output logic                   Running,
   output logic [$clog2(DEPTH):0] StackDepth,
   output logic                   StackOvf,
   output logic                   StackUnf
);

   state_e        state_r;
   state_e        state_nxt_s;
   pc_sel_e       sel_s;
   logic [A-1:0]  pc_r;
   logic [A-1:0]  pc_nxt_s;
   logic [A-1:0]  pc_inc_s;
   logic [A-1:0]  rel_ext_s;
   logic          running_r;
   logic          ovf_r;
   logic          unf_r;
   logic          push_s;
   logic          pop_s;
   logic          restart_s;
   logic          ovf_set_s;
   logic          unf_set_s;
   logic [A-1:0]  ras_top_s;
   logic          ras_full_s;
   logic          ras_empty_s;

   assign pc_inc_s  = pc_r + A'(1'b1);
   assign rel_ext_s = A'($signed(Offset));

   ret_addr_stack #(
      .A     (A),
      .DEPTH (DEPTH)
   ) u_ras (
      .clk   (clk),
      .clear (restart_s | ~Reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pc_inc_s),
      .top   (ras_top_s),
      .depth (StackDepth),
      .full  (ras_full_s),
      .empty (ras_empty_s)
   );

   // Run-control FSM and flag decode: choose next state, PC source and stack action.
   always_comb begin
      state_nxt_s = state_r;
      sel_s       = SEL_HOLD;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      restart_s   = 1'b0;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      case (state_r)
         IDLE, HALT: begin
            if (Start) begin
               state_nxt_s = RUN;
               sel_s       = SEL_START;
               restart_s   = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         RUN: begin
            if (Start) begin
               sel_s     = SEL_START;
               restart_s = 1'b1;
            end else if (Halt) begin
               state_nxt_s = HALT;
            end else if (Stall) begin
               sel_s = SEL_HOLD;
            end else if (ret_flag) begin
               if (!ras_empty_s) begin
                  sel_s = SEL_POP;
                  pop_s = 1'b1;
               end else begin
                  sel_s     = SEL_INC;
                  unf_set_s = 1'b1;
               end
            end else if (call_flag) begin
               sel_s     = SEL_ABS;
               push_s    = 1'b1;
               ovf_set_s = ras_full_s;
            end else if (jmp_flag) begin
               sel_s = SEL_ABS;
            end else if (beq_flag) begin
               sel_s = rel_flag ? SEL_REL : SEL_ABS;
            end else begin
               sel_s = SEL_INC;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Next-PC mux.
   always_comb begin
      pc_nxt_s = pc_r;
      case (sel_s)
         SEL_HOLD:  pc_nxt_s = pc_r;
         SEL_INC:   pc_nxt_s = pc_inc_s;
         SEL_ABS:   pc_nxt_s = Target;
         SEL_REL:   pc_nxt_s = pc_r + rel_ext_s;
         SEL_POP:   pc_nxt_s = ras_top_s;
         SEL_START: pc_nxt_s = A'(START_ADDR);
         default:   pc_nxt_s = pc_r;
      endcase
   end

   // State, PC and sticky stack-error flags; Reset low wins over everything.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_r   <= IDLE;
         running_r <= 1'b0;
         pc_r      <= {A{1'b0}};
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         running_r <= (state_nxt_s == RUN);
         pc_r      <= pc_nxt_s;
         ovf_r     <= restart_s ? 1'b0 : (ovf_r | ovf_set_s);
         unf_r     <= restart_s ? 1'b0 : (unf_r | unf_set_s);
      end
   end

   assign ProgCtr  = pc_r;
   assign Running  = running_r;
   assign StackOvf = ovf_r;
   assign StackUnf = unf_r;

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Self-checking bench for prog_ctr_ras: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours RAS_WRAP_EN like the design.
module tb_prog_ctr_ras;

   localparam int A          = 10;
   localparam int OW         = 6;
   localparam int DEPTH      = 4;
   localparam int START_ADDR = 0;
   localparam int MASK       = (1 << A) - 1;

   logic          clk = 1'b0;
   logic          Reset, Start, Halt, Stall;
   logic          beq_flag, rel_flag, jmp_flag, call_flag, ret_flag;
   logic [A-1:0]  Target;
   logic [OW-1:0] Offset;
   logic [A-1:0]  ProgCtr;
   logic          Running;
   logic [2:0]    StackDepth;
   logic          StackOvf, StackUnf;

   int checks   = 0;
   int failures = 0;

   // Reference model: 0=IDLE 1=RUN 2=HALT, PC as int, stack as queue (back = top).
   int m_state = 0;
   int m_pc    = 0;
   int m_ras[$];
   bit m_ovf   = 1'b0;
   bit m_unf   = 1'b0;

   always #5 clk = ~clk;

   prog_ctr_ras #(.A(A), .OW(OW), .DEPTH(DEPTH), .START_ADDR(START_ADDR)) dut (
      .clk(clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
      .beq_flag(beq_flag), .rel_flag(rel_flag), .jmp_flag(jmp_flag),
      .call_flag(call_flag), .ret_flag(ret_flag), .Target(Target), .Offset(Offset),
      .ProgCtr(ProgCtr), .Running(Running), .StackDepth(StackDepth),
      .StackOvf(StackOvf), .StackUnf(StackUnf)
   );

   task automatic model_restart();
      m_state = 1;
      m_pc    = START_ADDR;
      m_ras.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic model_step();
      int off;
      off = (Offset >= 6'd32) ? int'(Offset) - 64 : int'(Offset);
      if (!Reset) begin
         m_state = 0; m_pc = 0; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else if (m_state != 1) begin
         if (Start) model_restart();
      end else if (Start) begin
         model_restart();
      end else if (Halt) begin
         m_state = 2;
      end else if (!Stall) begin
         if (ret_flag) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = (m_pc + 1) & MASK; m_unf = 1'b1; end
         end else if (call_flag) begin
            if (m_ras.size() < DEPTH) m_ras.push_back((m_pc + 1) & MASK);
            else begin
               m_ovf = 1'b1;
`ifdef RAS_WRAP_EN
               void'(m_ras.pop_front());
               m_ras.push_back((m_pc + 1) & MASK);
`endif
            end
            m_pc = int'(Target);
         end else if (jmp_flag) m_pc = int'(Target);
         else if (beq_flag) m_pc = rel_flag ? ((m_pc + off) & MASK) : int'(Target);
         else m_pc = (m_pc + 1) & MASK;
      end
   endtask

   task automatic idle_in();
      Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
      beq_flag = 1'b0; rel_flag = 1'b0; jmp_flag = 1'b0; call_flag = 1'b0; ret_flag = 1'b0;
      Target = 10'h000; Offset = 6'h00;
   endtask

   // One clock: advance the model on the applied inputs, then sample 1 time unit after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_in(); Reset = 1'b0; Start = 1'b1; jmp_flag = 1'b1; Target = 10'h155; cycle();
      checks++; if (ProgCtr !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", ProgCtr); end
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", Running); end
      checks++; if (StackDepth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", StackDepth); end
      checks++; if ({StackOvf, StackUnf} !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", {StackOvf, StackUnf}); end
   endtask

   task automatic test_count();
      idle_in(); jmp_flag = 1'b1; Target = 10'h155; cycle();
      checks++; if (ProgCtr !== 10'h000 || Running !== 1'b0) begin failures++; $display("FAIL idle_hold pc=%h run=%b exp pc=000 run=0", ProgCtr, Running); end
      idle_in(); Start = 1'b1; cycle();
      checks++; if (ProgCtr !== 10'h000 || Running !== 1'b1) begin failures++; $display("FAIL start pc=%h run=%b exp pc=000 run=1", ProgCtr, Running); end
      idle_in();
      for (int i = 1; i <= 3; i++) begin
         cycle();
         checks++; if (ProgCtr !== A'(i)) begin failures++; $display("FAIL count got=%h exp=%h", ProgCtr, A'(i)); end
      end
      call_flag = 1'b1; Target = 10'h005; cycle();
      checks++; if (ProgCtr !== 10'h005 || StackDepth !== 3'd1) begin failures++; $display("FAIL call_to5 pc=%h depth=%0d exp pc=005 depth=1", ProgCtr, StackDepth); end
      idle_in(); Reset = 1'b0; Stall = 1'b1; jmp_flag = 1'b1; Target = 10'h200; cycle();
      checks++; if (ProgCtr !== 10'h000 || Running !== 1'b0 || StackDepth !== 3'd0) begin
         failures++; $display("FAIL midrun_reset pc=%h run=%b depth=%0d exp pc=000 run=0 depth=0", ProgCtr, Running, StackDepth); end
   endtask

   typedef struct packed {
      logic       beq; logic rel; logic jmp;
      logic [9:0] tgt; logic [5:0] off; logic [9:0] exp_pc;
   } br_t;

   task automatic test_branch();
      br_t tbl [7];
      tbl = '{'{1'b0, 1'b0, 1'b1, 10'h010, 6'h00, 10'h010},
              '{1'b1, 1'b1, 1'b0, 10'h3FF, 6'h3C, 10'h00C},
              '{1'b1, 1'b0, 1'b0, 10'h100, 6'h3C, 10'h100},
              '{1'b0, 1'b0, 1'b1, 10'h3FF, 6'h00, 10'h3FF},
              '{1'b0, 1'b0, 1'b0, 10'h155, 6'h2A, 10'h000},
              '{1'b1, 1'b1, 1'b0, 10'h2AA, 6'h3F, 10'h3FF},
              '{1'b1, 1'b1, 1'b0, 10'h000, 6'h1F, 10'h01E}};
      idle_in(); Start = 1'b1; cycle();
      for (int i = 0; i < 7; i++) begin
         idle_in();
         beq_flag = tbl[i].beq; rel_flag = tbl[i].rel; jmp_flag = tbl[i].jmp;
         Target = tbl[i].tgt; Offset = tbl[i].off;
         cycle();
         checks++; if (ProgCtr !== tbl[i].exp_pc) begin failures++; $display("FAIL branch_%0d got=%h exp=%h", i, ProgCtr, tbl[i].exp_pc); end
      end
   endtask

   typedef struct packed {
      logic call; logic ret; logic jmp;
      logic [9:0] tgt; logic [9:0] exp_pc; logic [2:0] exp_depth; logic exp_unf;
   } cr_t;

   task automatic test_calls();
      cr_t tbl [7];
      tbl = '{'{1'b0, 1'b0, 1'b1, 10'h020, 10'h020, 3'd0, 1'b0},
              '{1'b1, 1'b0, 1'b0, 10'h080, 10'h080, 3'd1, 1'b0},
              '{1'b0, 1'b0, 1'b0, 10'h000, 10'h081, 3'd1, 1'b0},
              '{1'b1, 1'b0, 1'b0, 10'h0C0, 10'h0C0, 3'd2, 1'b0},
              '{1'b0, 1'b1, 1'b0, 10'h3AA, 10'h082, 3'd1, 1'b0},
              '{1'b0, 1'b1, 1'b0, 10'h3AA, 10'h021, 3'd0, 1'b0},
              '{1'b0, 1'b1, 1'b0, 10'h3AA, 10'h022, 3'd0, 1'b1}};
      for (int i = 0; i < 7; i++) begin
         idle_in();
         call_flag = tbl[i].call; ret_flag = tbl[i].ret; jmp_flag = tbl[i].jmp; Target = tbl[i].tgt;
         cycle();
         checks++; if (ProgCtr !== tbl[i].exp_pc || StackDepth !== tbl[i].exp_depth || StackUnf !== tbl[i].exp_unf) begin
            failures++; $display("FAIL calls_%0d pc=%h depth=%0d unf=%b exp pc=%h depth=%0d unf=%b", i, ProgCtr, StackDepth, StackUnf,
                                 tbl[i].exp_pc, tbl[i].exp_depth, tbl[i].exp_unf); end
      end
   endtask

   task automatic test_overflow();
      logic [9:0] tgts [5];
      logic [9:0] rets [4];
      tgts = '{10'h100, 10'h200, 10'h300, 10'h180, 10'h280};
`ifdef RAS_WRAP_EN
      rets = '{10'h181, 10'h301, 10'h201, 10'h101};
`else
      rets = '{10'h301, 10'h201, 10'h101, 10'h001};
`endif
      idle_in(); Start = 1'b1; Stall = 1'b1; jmp_flag = 1'b1; Target = 10'h3AA; cycle();
      checks++; if (ProgCtr !== 10'h000 || StackDepth !== 3'd0 || StackUnf !== 1'b0) begin
         failures++; $display("FAIL restart_run pc=%h depth=%0d unf=%b exp pc=000 depth=0 unf=0", ProgCtr, StackDepth, StackUnf); end
      for (int i = 0; i < 5; i++) begin
         idle_in(); call_flag = 1'b1; Target = tgts[i]; cycle();
      end
      checks++; if (StackOvf !== 1'b1 || StackDepth !== 3'd4 || ProgCtr !== 10'h280) begin
         failures++; $display("FAIL ovf ovf=%b depth=%0d pc=%h exp ovf=1 depth=4 pc=280", StackOvf, StackDepth, ProgCtr); end
      for (int i = 0; i < 4; i++) begin
         idle_in(); ret_flag = 1'b1; cycle();
         checks++; if (ProgCtr !== rets[i]) begin failures++; $display("FAIL ovf_ret_%0d got=%h exp=%h", i, ProgCtr, rets[i]); end
      end
      checks++; if (StackDepth !== 3'd0 || StackOvf !== 1'b1) begin
         failures++; $display("FAIL ovf_drain depth=%0d ovf=%b exp depth=0 ovf=1", StackDepth, StackOvf); end
   endtask

   task automatic test_priority_stall();
      idle_in(); jmp_flag = 1'b1; Target = 10'h030; cycle();
      idle_in(); call_flag = 1'b1; Target = 10'h050; cycle();
      idle_in(); ret_flag = 1'b1; call_flag = 1'b1; jmp_flag = 1'b1; beq_flag = 1'b1; Target = 10'h200; cycle();
      checks++; if (ProgCtr !== 10'h031 || StackDepth !== 3'd0) begin
         failures++; $display("FAIL ret_priority pc=%h depth=%0d exp pc=031 depth=0", ProgCtr, StackDepth); end
      for (int i = 0; i < 3; i++) begin
         idle_in(); Stall = 1'b1; jmp_flag = 1'b1; Target = 10'h300; cycle();
         checks++; if (ProgCtr !== 10'h031) begin failures++; $display("FAIL stall_jmp_%0d got=%h exp=031", i, ProgCtr); end
      end
      idle_in(); Stall = 1'b1; call_flag = 1'b1; Target = 10'h300; cycle();
      idle_in(); Stall = 1'b1; ret_flag = 1'b1; cycle();
      checks++; if (StackDepth !== 3'd0 || StackUnf !== 1'b0 || ProgCtr !== 10'h031) begin
         failures++; $display("FAIL stall_stack depth=%0d unf=%b pc=%h exp depth=0 unf=0 pc=031", StackDepth, StackUnf, ProgCtr); end
      idle_in(); cycle();
      checks++; if (ProgCtr !== 10'h032) begin failures++; $display("FAIL stall_release got=%h exp=032", ProgCtr); end
   endtask

   task automatic test_halt();
      idle_in(); jmp_flag = 1'b1; Target = 10'h03F; cycle();
      idle_in(); call_flag = 1'b1; Target = 10'h040; cycle();
      idle_in(); Halt = 1'b1; Stall = 1'b1; jmp_flag = 1'b1; call_flag = 1'b1; Target = 10'h123; cycle();
      checks++; if (ProgCtr !== 10'h040 || Running !== 1'b0 || StackDepth !== 3'd1) begin
         failures++; $display("FAIL halt pc=%h run=%b depth=%0d exp pc=040 run=0 depth=1", ProgCtr, Running, StackDepth); end
      for (int i = 0; i < 3; i++) begin
         idle_in(); ret_flag = (i == 0); call_flag = (i == 1); jmp_flag = 1'b1; Target = 10'h2F0; cycle();
         checks++; if (ProgCtr !== 10'h040 || Running !== 1'b0 || StackDepth !== 3'd1) begin
            failures++; $display("FAIL halt_hold_%0d pc=%h run=%b depth=%0d exp pc=040 run=0 depth=1", i, ProgCtr, Running, StackDepth); end
      end
      idle_in(); Start = 1'b1; cycle();
      checks++; if (ProgCtr !== A'(START_ADDR) || Running !== 1'b1 || StackDepth !== 3'd0 || {StackOvf, StackUnf} !== 2'b00) begin
         failures++; $display("FAIL halt_start pc=%h run=%b depth=%0d sticky=%b exp pc=000 run=1 depth=0 sticky=00",
                              ProgCtr, Running, StackDepth, {StackOvf, StackUnf}); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         idle_in();
         Reset     = ($urandom_range(0, 63) != 0);
         Start     = ($urandom_range(0, 31) == 0);
         Halt      = ($urandom_range(0, 31) == 0);
         Stall     = ($urandom_range(0, 4) == 0);
         beq_flag  = ($urandom_range(0, 3) == 0);
         rel_flag  = $urandom_range(0, 1);
         jmp_flag  = ($urandom_range(0, 3) == 0);
         call_flag = ($urandom_range(0, 3) == 0);
         ret_flag  = ($urandom_range(0, 3) == 0);
         Target    = A'($urandom_range(0, MASK));
         Offset    = OW'($urandom_range(0, 63));
         cycle();
         checks++; if (ProgCtr !== A'(m_pc)) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, ProgCtr, A'(m_pc)); end
         checks++; if (Running !== (m_state == 1)) begin failures++; $display("FAIL rnd_running cyc=%0d got=%b exp=%b", n, Running, (m_state == 1)); end
         checks++; if (StackDepth !== 3'(m_ras.size())) begin failures++; $display("FAIL rnd_depth cyc=%0d got=%0d exp=%0d", n, StackDepth, m_ras.size()); end
         checks++; if (StackOvf !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, StackOvf, m_ovf); end
         checks++; if (StackUnf !== m_unf) begin failures++; $display("FAIL rnd_unf cyc=%0d got=%b exp=%b", n, StackUnf, m_unf); end
      end
   endtask

   initial begin
      idle_in();
      #2;
      test_reset();
      test_count();
      test_branch();
      test_calls();
      test_overflow();
      test_priority_stall();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
